// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the conv window streamer.
package conv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StStream,
    StSlide,
    StRefill
  } cws_state_t;

  function automatic int unsigned beats_per_row(input int unsigned cols, input int unsigned mem_w);
    return cols / mem_w;
  endfunction

  function automatic int unsigned win_elems(input int unsigned win);
    return win * win;
  endfunction

  // Index width that stays at least 1 bit for degenerate sizes.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_window_streamer_row_shift_buffer.sv
// WIN x COLS pixel band: beat-wide writes, whole-band shift up by one row, random read.
module row_shift_buffer
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WIN    = 4,
  parameter int unsigned COLS   = 16,
  parameter int unsigned MEM_W  = 4,
  localparam int unsigned RIW   = idx_w(WIN),
  localparam int unsigned BIW   = idx_w(beats_per_row(COLS, MEM_W)),
  localparam int unsigned CIW   = idx_w(COLS)
) (
  input  logic                    clk,
  input  logic                    shift_up,
  input  logic                    wr_en,
  input  logic [RIW-1:0]          wr_row,
  input  logic [BIW-1:0]          wr_beat,
  input  logic [MEM_W*DATA_W-1:0] wr_data,
  input  logic [RIW-1:0]          rd_row,
  input  logic [CIW-1:0]          rd_col,
  output logic [DATA_W-1:0]       rd_data
);

  localparam int unsigned NCells = WIN * COLS;
  localparam int unsigned AW     = idx_w(NCells);

  logic [DATA_W-1:0] cells [NCells];
  logic [AW-1:0]     rd_idx;

  for (genvar r = 0; r < WIN; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int unsigned Idx = r * COLS + c;
      logic [DATA_W-1:0] cell_q;
      logic [DATA_W-1:0] shift_src;

      if (r < WIN - 1) begin : g_src
        assign shift_src = cells[AW'(Idx + COLS)];
      end else begin : g_keep
        assign shift_src = cell_q;
      end

      always_ff @(posedge clk) begin
        if (shift_up) begin
          cell_q <= shift_src;
        end else if (wr_en && wr_row == RIW'(r) && wr_beat == BIW'(c / MEM_W)) begin
          cell_q <= wr_data[(c % MEM_W)*DATA_W +: DATA_W];
        end
      end

      assign cells[AW'(Idx)] = cell_q;
    end
  end

  // Read-during-write returns the incoming pixel so a band can start on its final beat.
  always_comb begin
    rd_idx  = AW'(rd_row) * AW'(COLS) + AW'(rd_col);
    rd_data = cells[rd_idx];
    for (int p = 0; p < MEM_W; p++) begin
      if (wr_en && !shift_up && wr_row == rd_row &&
          32'(rd_col) == 32'(wr_beat) * MEM_W + p) begin
        rd_data = wr_data[p*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/conv_window_streamer.sv
// Streams every WIN x WIN window of a sliding WIN-row band to the PE array, row-major.
module conv_window_streamer
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WIN    = 4,
  parameter int unsigned COLS   = 16,
  parameter int unsigned MEM_W  = 4,
  parameter int unsigned ROW_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ROW_W-1:0]         cfg_img_rows,
  input  logic [$clog2(WIN+1)-1:0] cfg_stride,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MEM_W*DATA_W-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_win_last,
  output logic                     out_band_last,
  output logic                     busy,
  output logic                     done,
  output logic                     err_cfg
);

  localparam int unsigned BEATS_PER_ROW = beats_per_row(COLS, MEM_W);
  localparam int unsigned WIN_ELEMS     = win_elems(WIN);
  localparam int unsigned SW  = $clog2(WIN + 1);
  localparam int unsigned RIW = idx_w(WIN);
  localparam int unsigned BIW = idx_w(BEATS_PER_ROW);
  localparam int unsigned CIW = idx_w(COLS);
  localparam int unsigned CW  = idx_w(COLS + 1);
  localparam int unsigned EW  = idx_w(WIN_ELEMS);

  cws_state_t        state_q, state_d;
  logic [ROW_W-1:0]  rows_cfg_q, rows_cfg_d, rows_q, rows_d;
  logic [SW-1:0]     stride_q, stride_d;
  logic [BIW-1:0]    beat_q, beat_d;
  logic [RIW-1:0]    fill_row_q, fill_row_d;
  logic [CW-1:0]     ptr_c_q, ptr_c_d;
  logic [RIW-1:0]    ptr_er_q, ptr_er_d, ptr_ec_q, ptr_ec_d;
  logic [EW-1:0]     ptr_e_q, ptr_e_d;
  logic              out_valid_q, out_valid_d, win_last_q, win_last_d;
  logic              band_last_q, band_last_d, done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              accept, xfer, beat_last, band_start, load, shift_up;
  logic [CW-1:0]     ld_c, nxt_c;
  logic [RIW-1:0]    ld_er, ld_ec, nxt_er, nxt_ec, wr_row;
  logic [EW-1:0]     ld_e, nxt_e;
  logic              ld_win_last, ld_band_last;
  logic [CIW-1:0]    rd_col;
  logic [DATA_W-1:0] rd_data;

  assign in_ready   = (state_q == StFill) || (state_q == StRefill);
  assign busy       = (state_q != StIdle);
  assign accept     = in_valid && in_ready;
  assign xfer       = out_valid_q && out_ready;
  assign beat_last  = (beat_q == BIW'(BEATS_PER_ROW - 1));
  assign band_start = accept && beat_last &&
                      (state_q == StRefill || fill_row_q == RIW'(WIN - 1));
  // The next element is fetched either on the band's final beat or as the current one leaves.
  assign load       = band_start || (xfer && !band_last_q);
  assign wr_row     = (state_q == StRefill) ? RIW'(WIN - 1) : fill_row_q;

  row_shift_buffer #(
    .DATA_W(DATA_W),
    .WIN   (WIN),
    .COLS  (COLS),
    .MEM_W (MEM_W)
  ) u_buf (
    .clk     (clk),
    .shift_up(shift_up),
    .wr_en   (accept),
    .wr_row  (wr_row),
    .wr_beat (beat_q),
    .wr_data (in_data),
    .rd_row  (ld_er),
    .rd_col  (rd_col),
    .rd_data (rd_data)
  );

  always_comb begin
    ld_c   = band_start ? '0 : ptr_c_q;
    ld_er  = band_start ? '0 : ptr_er_q;
    ld_ec  = band_start ? '0 : ptr_ec_q;
    ld_e   = band_start ? '0 : ptr_e_q;
    rd_col = CIW'(ld_c + CW'(ld_ec));
    ld_win_last  = (ld_e == EW'(WIN_ELEMS - 1));
    ld_band_last = ld_win_last && (32'(ld_c) + 32'(stride_q) + WIN > COLS);
    nxt_e  = ld_win_last ? '0 : ld_e + 1'b1;
    nxt_c  = ld_c;
    nxt_er = ld_er;
    nxt_ec = ld_ec + 1'b1;
    if (ld_ec == RIW'(WIN - 1)) begin
      nxt_ec = '0;
      if (ld_er == RIW'(WIN - 1)) begin
        nxt_er = '0;
        nxt_c  = ld_c + CW'(stride_q);
      end else begin
        nxt_er = ld_er + 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rows_cfg_d  = rows_cfg_q;
    stride_d    = stride_q;
    rows_d      = rows_q;
    beat_d      = beat_q;
    fill_row_d  = fill_row_q;
    ptr_c_d     = ptr_c_q;
    ptr_er_d    = ptr_er_q;
    ptr_ec_d    = ptr_ec_q;
    ptr_e_d     = ptr_e_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    win_last_d  = win_last_q;
    band_last_d = band_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    shift_up    = 1'b0;

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = rd_data;
      win_last_d  = ld_win_last;
      band_last_d = ld_band_last;
      ptr_c_d     = nxt_c;
      ptr_er_d    = nxt_er;
      ptr_ec_d    = nxt_ec;
      ptr_e_d     = nxt_e;
    end else if (xfer) begin
      out_valid_d = 1'b0;
      win_last_d  = 1'b0;
      band_last_d = 1'b0;
    end

    if (accept) beat_d = beat_last ? '0 : beat_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cfg_stride == '0 || 32'(cfg_stride) > WIN || 32'(cfg_img_rows) < WIN) begin
            err_d = 1'b1;
          end else begin
            rows_cfg_d = cfg_img_rows;
            stride_d   = cfg_stride;
            rows_d     = ROW_W'(WIN);
            beat_d     = '0;
            fill_row_d = '0;
            state_d    = StFill;
          end
        end
      end
      StFill: begin
        if (band_start) state_d = StStream;
        else if (accept && beat_last) fill_row_d = fill_row_q + 1'b1;
      end
      StStream: begin
        if (xfer && band_last_q) begin
          if (rows_q == rows_cfg_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StSlide;
          end
        end
      end
      StSlide: begin
        shift_up = 1'b1;
        rows_d   = rows_q + 1'b1;
        beat_d   = '0;
        state_d  = StRefill;
      end
      StRefill: begin
        if (band_start) state_d = StStream;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      rows_cfg_q  <= '0;
      stride_q    <= '0;
      rows_q      <= '0;
      beat_q      <= '0;
      fill_row_q  <= '0;
      ptr_c_q     <= '0;
      ptr_er_q    <= '0;
      ptr_ec_q    <= '0;
      ptr_e_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      win_last_q  <= 1'b0;
      band_last_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_cfg_q  <= rows_cfg_d;
      stride_q    <= stride_d;
      rows_q      <= rows_d;
      beat_q      <= beat_d;
      fill_row_q  <= fill_row_d;
      ptr_c_q     <= ptr_c_d;
      ptr_er_q    <= ptr_er_d;
      ptr_ec_q    <= ptr_ec_d;
      ptr_e_q     <= ptr_e_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      win_last_q  <= win_last_d;
      band_last_q <= band_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_win_last  = win_last_q;
  assign out_band_last = band_last_q;
  assign done          = done_q;
  assign err_cfg       = err_q;

endmodule
